// File: rtl/spi_out_arbiter_pkg.sv
// Shared timing constants, state encoding and counter-load helpers for the SPI output arbiter.
// No logic of its own; imported by the arbiter and its slot timer.
package spi_out_arbiter_pkg;

    localparam int SLOT_CYCLES     = 16;
    localparam int FRAME_TAIL      = 17;
    localparam int GAP_DEFAULT     = 2;
    localparam int HOLDOFF_DEFAULT = 18;
    localparam int CNT_W           = 5;
    localparam int WORD_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_SLOT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // The timer is loaded one cycle after a write and the decision is taken one
    // cycle before the registered write lands, hence the two-cycle trim.
    function automatic cnt_t slot_load();
        return cnt_t'(SLOT_CYCLES - 2);
    endfunction

    // Last write -> GAP (+1) -> IDLE (+1) -> ISSUE (+1): three cycles of overhead.
    function automatic cnt_t gap_load(input int gap);
        return cnt_t'(FRAME_TAIL + gap - 3);
    endfunction

endpackage

// File: rtl/spi_out_arbiter_slot_timer.sv
// Loadable down-counter that saturates at zero; done_o is high while the count is zero.
// Load takes effect on the next cycle; no backpressure.
module slot_timer
    import spi_out_arbiter_pkg::*;
#(
    parameter cnt_t RST_VAL = '0
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  cnt_t value_i,
    output logic done_o
);

    cnt_t count_q;
    cnt_t count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/spi_out_arbiter.sv
// Two-requester round-robin arbiter feeding one 16-bit SPI serializer, one word per 16 cycles.
// Registered outputs: a word is written and acked one cycle after its slot decision; requesters hold until ack.
module spi_out_arbiter
    import spi_out_arbiter_pkg::*;
#(
    parameter int GAP     = GAP_DEFAULT,
    parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [WORD_W-1:0] data0,
    input  logic [WORD_W-1:0] data1,
    input  logic              last0,
    input  logic              last1,
    output logic              ack0,
    output logic              ack1,
    output logic              writeSPI,
    output logic [WORD_W-1:0] spiData,
    output logic [1:0]        grant,
    output logic              underrun
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic              write_q, write_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              underrun_q, underrun_d;
    logic [WORD_W-1:0] data_q, data_d;

    logic              tmr_load;
    cnt_t              tmr_val;
    logic              tmr_done;

    logic              owner_req;
    logic              owner_last;
    logic [WORD_W-1:0] owner_data;
    logic              winner;

    assign owner_req  = owner_q ? req1  : req0;
    assign owner_last = owner_q ? last1 : last0;
    assign owner_data = owner_q ? data1 : data0;
    // With both requesting, the round-robin pointer names the winner.
    assign winner     = (req0 && req1) ? ptr_q : req1;

    slot_timer #(
        .RST_VAL (cnt_t'(HOLDOFF))
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .done_o  (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        write_d    = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        underrun_d = 1'b0;
        data_d     = data_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_ISSUE;
                    owner_d = winner;
                    grant_d = winner ? 2'b10 : 2'b01;
                    write_d = 1'b1;
                    ack0_d  = !winner;
                    ack1_d  = winner;
                    data_d  = winner ? data1 : data0;
                end
            end

            ST_ISSUE: begin
                tmr_load = 1'b1;
                if (owner_last) begin
                    state_d = ST_GAP;
                    grant_d = 2'b00;
                    ptr_d   = !owner_q;
                    tmr_val = gap_load(GAP);
                end else begin
                    state_d = ST_SLOT;
                    tmr_val = slot_load();
                end
            end

            ST_SLOT: begin
                if (tmr_done) begin
                    if (owner_req) begin
                        state_d = ST_ISSUE;
                        write_d = 1'b1;
                        ack0_d  = !owner_q;
                        ack1_d  = owner_q;
                        data_d  = owner_data;
                    end else begin
                        // Owner missed its slot: abandon the frame, let chip select rise.
                        state_d    = ST_GAP;
                        underrun_d = 1'b1;
                        grant_d    = 2'b00;
                        ptr_d      = !owner_q;
                        tmr_load   = 1'b1;
                        tmr_val    = gap_load(GAP);
                    end
                end
            end

            ST_GAP: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_GAP;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_GAP;
            owner_q    <= 1'b0;
            ptr_q      <= 1'b0;
            grant_q    <= 2'b00;
            write_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            underrun_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            write_q    <= write_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            underrun_q <= underrun_d;
            data_q     <= data_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign writeSPI = write_q;
    assign spiData  = data_q;
    assign grant    = grant_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_out_arbiter.sv
// Randomized requesters push expected words into per-requester queues; a negedge monitor
// checks every write, slot, underrun and gap against a frame-level model of the arbiter rules.
module tb_spi_out_arbiter;

    localparam int GAP     = 2;
    localparam int HOLDOFF = 18;
    localparam int SLOT    = 16;
    localparam int TAIL    = 17;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } word_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_r, req1_r, last0_r, last1_r;
    logic [15:0] data0_r, data1_r;
    logic        ack0, ack1, writeSPI, underrun;
    logic [15:0] spiData;
    logic [1:0]  grant;

    int    total = 0;
    int    bad   = 0;
    word_t q0[$];
    word_t q1[$];
    int    owners_log[$];

    int    cyc         = 0;
    bit    prev_reset  = 1'b1;
    bit    pr0         = 1'b0;
    bit    pr1         = 1'b0;
    bit    mf_active   = 1'b0;
    bit    owner_m     = 1'b0;
    bit    ptr_m       = 1'b0;
    bit    exact       = 1'b0;
    int    last_wr     = 0;
    int    earliest    = 0;
    int    last_rst    = 0;

    spi_out_arbiter #(
        .GAP     (GAP),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req0     (req0_r),
        .req1     (req1_r),
        .data0    (data0_r),
        .data1    (data1_r),
        .last0    (last0_r),
        .last1    (last1_r),
        .ack0     (ack0),
        .ack1     (ack1),
        .writeSPI (writeSPI),
        .spiData  (spiData),
        .grant    (grant),
        .underrun (underrun)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [1:0] oh(input bit n);
        return n ? 2'b10 : 2'b01;
    endfunction

    task automatic set_req(input bit n, input logic r, input logic [15:0] d, input logic l);
        if (n == 1'b0) begin
            req0_r = r; data0_r = d; last0_r = l;
        end else begin
            req1_r = r; data1_r = d; last1_r = l;
        end
    endtask

    function automatic logic ack_of(input bit n);
        return n ? ack1 : ack0;
    endfunction

    task automatic push_exp(input bit n, input logic [15:0] d, input logic l);
        word_t w;
        w.d = d;
        w.l = l;
        if (n == 1'b0) q0.push_back(w);
        else           q1.push_back(w);
    endtask

    // Pop and compare one written word; a last word closes the frame in the model.
    task automatic check_word(input bit n);
        word_t w;
        bit    have;
        have = (n == 1'b0) ? (q0.size() != 0) : (q1.size() != 0);
        chk(have, "sb_nonempty", 0, 1);
        last_wr = cyc;
        if (have) begin
            w = (n == 1'b0) ? q0.pop_front() : q1.pop_front();
            chk(spiData == w.d, "spi_data", spiData, w.d);
            if (w.l) begin
                mf_active = 1'b0;
                ptr_m     = !n;
                earliest  = cyc + TAIL + GAP;
                exact     = 1'b1;
            end
        end
    endtask

    always @(negedge clock) begin
        bit was_active;
        bit n;
        bit pr_own;
        bit exp_owner;
        cyc++;
        if (prev_reset) begin
            chk(grant == 2'b00, "rst_grant", grant, 0);
            chk(!writeSPI, "rst_write", writeSPI, 0);
            chk(!ack0 && !ack1, "rst_ack", {ack1, ack0}, 0);
            chk(!underrun, "rst_underrun", underrun, 0);
            chk(spiData == 16'h0, "rst_data", spiData, 0);
            mf_active = 1'b0;
            ptr_m     = 1'b0;
            exact     = 1'b0;
            earliest  = cyc + HOLDOFF;
            last_rst  = cyc;
        end else begin
            n = ack1;
            if (writeSPI || ack0 || ack1)
                chk(writeSPI && (ack0 != ack1), "ack_strobe", {writeSPI, ack1, ack0}, ack1 ? 6 : 5);
            was_active = mf_active;
            if (!was_active && exact && cyc == earliest && (pr0 || pr1))
                chk(writeSPI, "gap_exact", writeSPI, 1);
            if (was_active && cyc == last_wr + SLOT) begin
                pr_own = owner_m ? pr1 : pr0;
                if (pr_own) begin
                    chk(writeSPI && n == owner_m, "slot_write", {writeSPI, n}, {1'b1, owner_m});
                    chk(!underrun, "slot_no_underrun", underrun, 0);
                    chk(grant == oh(owner_m), "grant_frame", grant, oh(owner_m));
                    if (writeSPI) begin
                        check_word(n);
                    end else begin
                        mf_active = 1'b0;
                        ptr_m     = !owner_m;
                        earliest  = last_wr + TAIL + GAP;
                        exact     = 1'b0;
                    end
                end else begin
                    chk(underrun && !writeSPI, "underrun_pulse", {underrun, writeSPI}, 2);
                    chk(grant == 2'b00, "grant_after_underrun", grant, 0);
                    mf_active = 1'b0;
                    ptr_m     = !owner_m;
                    earliest  = last_wr + TAIL + GAP;
                    exact     = 1'b0;
                end
            end else if (was_active) begin
                chk(!writeSPI && !underrun && grant == oh(owner_m), "slot_quiet",
                    {writeSPI, underrun, grant}, {2'b00, oh(owner_m)});
            end else if (writeSPI) begin
                exp_owner = (pr0 && pr1) ? ptr_m : pr1;
                chk(pr0 || pr1, "req_before_grant", {pr1, pr0}, 1);
                chk(n == exp_owner, "rr_owner", n, exp_owner);
                chk(cyc >= earliest, "frame_spacing", cyc, earliest);
                chk(grant == oh(n), "grant_first", grant, oh(n));
                chk(!underrun, "first_no_underrun", underrun, 0);
                mf_active = 1'b1;
                owner_m   = n;
                owners_log.push_back(int'(n));
                check_word(n);
            end else begin
                chk(!underrun && grant == 2'b00, "idle_quiet", {underrun, grant}, 0);
            end
        end
        prev_reset = reset;
        pr0        = req0_r;
        pr1        = req1_r;
    end

    task automatic wait_ack(input bit n, output bit got);
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clock);
            if (ack_of(n)) got = 1'b1;
        end
        if (!got) chk(got, "ack_timeout", n, 1);
        @(posedge clock);
        #1;
    endtask

    // Request line low; the data/last lines carry junk that must never reach spiData.
    task automatic idle_garbage(input bit n, input int k);
        for (int i = 0; i < k; i++) begin
            set_req(n, 1'b0, 16'($urandom), 1'($urandom));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic run_requester(input bit n, input int frames, input bit stream);
        for (int f = 0; f < frames; f++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int w = 0; w < len; w++) begin
                bit          got;
                logic [15:0] d;
                d = 16'($urandom);
                set_req(n, 1'b1, d, (w == len - 1));
                push_exp(n, d, (w == len - 1));
                wait_ack(n, got);
                set_req(n, 1'b0, d, (w == len - 1));
                if (!got) break;
                if (w != len - 1) begin
                    if (!stream && $urandom_range(0, 4) == 0) begin
                        idle_garbage(n, 20);
                        break;
                    end
                    idle_garbage(n, stream ? 0 : $urandom_range(0, 10));
                end
            end
            if (!stream) idle_garbage(n, $urandom_range(0, 25));
        end
    endtask

    task automatic settle();
        repeat (50) @(posedge clock);
        #1;
        chk(q0.size() == 0 && q1.size() == 0 && !mf_active, "drain",
            q0.size() + q1.size(), 0);
    endtask

    initial begin
        bit got;
        int t_rel;
        set_req(1'b0, 1'b0, 16'h0, 1'b0);
        set_req(1'b1, 1'b0, 16'h0, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Both requesters streaming from the first grant: strict alternation from requester 0.
        owners_log.delete();
        fork
            run_requester(1'b0, 3, 1'b1);
            run_requester(1'b1, 3, 1'b1);
        join
        settle();
        chk(owners_log.size() == 6, "stream_frames", owners_log.size(), 6);
        for (int i = 0; i < owners_log.size() && i < 6; i++)
            chk(owners_log[i] == (i % 2), "stream_owner", owners_log[i], i % 2);

        // Random lengths, pacing and mid-frame drops.
        fork
            run_requester(1'b0, 10, 1'b0);
            run_requester(1'b1, 10, 1'b0);
        join
        settle();

        // Reset five cycles into a word: the pending word is dropped, holdoff is honoured.
        set_req(1'b0, 1'b1, 16'hA5A5, 1'b0);
        push_exp(1'b0, 16'hA5A5, 1'b0);
        wait_ack(1'b0, got);
        set_req(1'b0, 1'b1, 16'h5A5A, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        set_req(1'b0, 1'b1, 16'h1234, 1'b1);
        push_exp(1'b0, 16'h1234, 1'b1);
        wait_ack(1'b0, got);
        set_req(1'b0, 1'b0, 16'h0, 1'b0);
        t_rel = last_rst;
        chk(got && (last_wr - t_rel >= HOLDOFF), "holdoff", last_wr - t_rel, HOLDOFF);
        settle();

        fork
            run_requester(1'b0, 4, 1'b0);
            run_requester(1'b1, 4, 1'b0);
        join
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
